oh_rrarb2_mux: RTL and testbench
================================

# oh_rrarb2_mux

Two-input packet arbiter with a registered output stage. It merges two valid/ready streams onto one output stream. The selection is a one-hot grant feeding an AND-OR data mux (grant_a & a_data | grant_b & b_data), built from the asiclib and-or cells. Grants alternate round-robin at packet granularity, so a packet (beats up to and including `last`) is never interleaved. It sits directly upstream of the and-or select logic and drives the merged datapath.

## Interface
- DW, 32, data width per stream
- PROP, "DEFAULT", cell property string passed to and-or cells

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- a_valid  input  1  stream A beat valid
- a_data  input  DW  stream A payload
- a_last  input  1  stream A final beat of packet
- a_ready  output  1  stream A beat accepted this cycle when a_valid & a_ready
- b_valid, b_data, b_last, b_ready  same as A for stream B
- out_valid  output  1  registered output beat valid
- out_data  output  DW  registered payload
- out_last  output  1  registered last flag
- out_src  output  1  source of current output beat (0=A, 1=B)
- out_ready  input  1  downstream accepts beat when out_valid & out_ready

## Operation
- States: IDLE, LOCK_A, LOCK_B. Round-robin pointer `ptr` (0 = A has priority).
- adv = ~out_valid | out_ready (output register can load).
- IDLE grant (combinational):
  - only one valid → that stream.
  - both valid → stream `ptr`.
  - none → no grant.
- LOCK_A: grant A only, B ignored. LOCK_B: grant B only.
- a_ready = grant_a & adv; b_ready = grant_b & adv. Never both high.
- On accepted beat from X:
  - out_data/out_last ← X's, out_valid ← 1, out_src ← X.
  - If X_last=0 → LOCK_X.
  - If X_last=1 → IDLE and ptr ← ~X.
- adv=1 with no accepted beat → out_valid ← 0.
- Grant ≠ consumption. In LOCK_X with X_valid=0, hold LOCK_X. The output drains normally and no other stream is granted.
- Single-beat packets (last=1 on first beat) never leave IDLE.
- Data mux is AND-OR of one-hot grant. With no grant, the mux output is 0, but the register does not load.

## Timing
- Reset (synchronous): state=IDLE, ptr=0, out_valid=0, out_data=0, out_last=0, out_src=0. a_ready/b_ready are 0 in the reset cycle.
- Latency: input accept at edge N → out_valid at N+1. Full throughput of 1 beat/cycle with out_ready held high.
- out_ready→a_ready/b_ready is a combinational path (permitted). No other input-to-output combinational paths.
- Backpressure: out_valid=1 & out_ready=0 holds out_data/out_last/out_src stable and deasserts a_ready/b_ready.
- Simultaneous: drain and load in the same cycle when out_ready=1 and a granted beat is valid (no bubble).
- Pointer update takes effect for arbitration in the cycle after the last beat is accepted.
- Reset mid-packet aborts the lock. Any partially transferred packet is dropped on the output, and the next cycle arbitrates from ptr=0.

## Structure
- Shared package oh_arb_pkg:
  - state encoding (IDLE=2'b00, LOCK_A=2'b01, LOCK_B=2'b10)
  - source IDs SRC_A=0, SRC_B=1
- Sub-module oh_rr_pick2: inputs req[1:0], ptr, lock state; output one-hot gnt[1:0]. Purely combinational, reused by wider arbiters.
- Data mux instantiates and-or cells per bit, with PROP passed through.

## Test plan
- A single-beat packets only, data 0x11,0x22,0x33, out_ready=1 → out_data 0x11,0x22,0x33 on consecutive cycles, out_src=0, one-cycle latency.
- Both valid from reset, each sending single-beat packets (A=0xA0.., B=0xB0..) → output alternates A,B,A,B starting with A (ptr=0).
- A sends 3-beat packet (last on beat 3) while B valid throughout → three A beats contiguous, then B. b_ready=0 during LOCK_A.
- out_ready=0 for 4 cycles with out_valid=1 → out_data stable, a_ready=b_ready=0. Release → no beat lost or duplicated.
- A mid-packet: a_valid drops for 2 cycles while B valid → no B beats, out_valid falls after drain. A resumes and completes, then B granted.
- reset asserted after beat 1 of a 3-beat A packet → next cycle out_valid=0, state IDLE, and both valid → A granted (ptr=0).

Source files
------------

// File: rtl/oh_arb_pkg.sv
// Shared definitions for the oh_* packet arbiters: lock-state encoding and source IDs.
package oh_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOCK_A = 2'b01,
        ST_LOCK_B = 2'b10
    } arb_state_e;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/asic_ao22.sv
// Two-term and-or cell: z = (a0 & a1) | (b0 & b1).
module asic_ao22 #(
    parameter PROP = "DEFAULT"
) (
    input  logic a0,
    input  logic a1,
    input  logic b0,
    input  logic b1,
    output logic z
);

    // Non-default PROP values are bound to a specific library cell at mapping time;
    // the logic function is the same either way.
    if (PROP == "DEFAULT") begin : g_generic
        assign z = (a0 & a1) | (b0 & b1);
    end else begin : g_prop
        assign z = (a0 & a1) | (b0 & b1);
    end

endmodule

// File: rtl/oh_rr_pick2.sv
// Two-way round-robin picker honouring a packet lock; produces a one-hot (or zero) grant.
module oh_rr_pick2
    import oh_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    input  arb_state_e state,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (state)
            ST_IDLE: begin
                if (req == 2'b11) begin
                    gnt = (ptr == SRC_B) ? 2'b10 : 2'b01;
                end else begin
                    gnt = req;
                end
            end
            // A lock grants its owner even while that stream has no valid beat.
            ST_LOCK_A: gnt = 2'b01;
            ST_LOCK_B: gnt = 2'b10;
            default:   gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/oh_rrarb2_mux.sv
// Two-input packet arbiter merging two valid/ready streams into one registered output.
//
// state     | meaning
// ST_IDLE   | between packets, arbitrate round-robin on ptr
// ST_LOCK_A | inside an A packet, only A may advance
// ST_LOCK_B | inside a B packet, only B may advance
module oh_rrarb2_mux
    import oh_arb_pkg::*;
#(
    parameter int DW   = 32,
    parameter     PROP = "DEFAULT"
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_valid,
    input  logic [DW-1:0] a_data,
    input  logic          a_last,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [DW-1:0] b_data,
    input  logic          b_last,
    output logic          b_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          out_src,
    input  logic          out_ready
);

    arb_state_e    state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic          out_src_q, out_src_d;

    logic [1:0]    gnt;
    logic          adv;
    logic          acc_a;
    logic          acc_b;
    logic [DW:0]   a_bus;
    logic [DW:0]   b_bus;
    logic [DW:0]   mux_out;

    oh_rr_pick2 u_pick (
        .req   ({b_valid, a_valid}),
        .ptr   (ptr_q),
        .state (state_q),
        .gnt   (gnt)
    );

    assign adv     = ~out_valid_q | out_ready;
    assign a_ready = gnt[0] & adv & ~reset;
    assign b_ready = gnt[1] & adv & ~reset;
    assign acc_a   = a_valid & a_ready;
    assign acc_b   = b_valid & b_ready;

    // The last flag rides through the same and-or select as the payload.
    assign a_bus = {a_last, a_data};
    assign b_bus = {b_last, b_data};

    for (genvar i = 0; i <= DW; i++) begin : g_ao
        asic_ao22 #(.PROP(PROP)) u_ao (
            .a0 (gnt[0]),
            .a1 (a_bus[i]),
            .b0 (gnt[1]),
            .b1 (b_bus[i]),
            .z  (mux_out[i])
        );
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        if (adv) begin
            if (acc_a | acc_b) begin
                out_valid_d = 1'b1;
                out_data_d  = mux_out[DW-1:0];
                out_last_d  = mux_out[DW];
                out_src_d   = acc_b ? SRC_B : SRC_A;
                if (mux_out[DW]) begin
                    state_d = ST_IDLE;
                    ptr_d   = acc_b ? SRC_A : SRC_B;
                end else begin
                    state_d = acc_b ? ST_LOCK_B : ST_LOCK_A;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= SRC_A;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= SRC_A;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_oh_rrarb2_mux.sv
// Directed cycle-by-cycle bench for oh_rrarb2_mux.
module tb_oh_rrarb2_mux;

    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          a_valid, a_last, a_ready;
    logic [DW-1:0] a_data;
    logic          b_valid, b_last, b_ready;
    logic [DW-1:0] b_data;
    logic          out_valid, out_last, out_src, out_ready;
    logic [DW-1:0] out_data;

    int checks = 0;
    int errors = 0;

    oh_rrarb2_mux #(.DW(DW), .PROP("DEFAULT")) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_last    (a_last),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_last    (b_last),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          av;
        logic [DW-1:0] ad;
        logic          al;
        logic          bv;
        logic [DW-1:0] bd;
        logic          bl;
        logic          ordy;
        logic          e_ar;
        logic          e_br;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic          e_ol;
        logic          e_os;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic av, input logic [DW-1:0] ad,
                                input logic al, input logic bv, input logic [DW-1:0] bd,
                                input logic bl, input logic ordy, input logic e_ar,
                                input logic e_br, input logic e_ov, input logic [DW-1:0] e_od,
                                input logic e_ol, input logic e_os);
        vec_t v;
        v.rst = rst; v.av = av; v.ad = ad; v.al = al;
        v.bv = bv; v.bd = bd; v.bl = bl; v.ordy = ordy;
        v.e_ar = e_ar; v.e_br = e_br; v.e_ov = e_ov;
        v.e_od = e_od; v.e_ol = e_ol; v.e_os = e_os;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check readies before the edge, check outputs after it.
    task automatic step(input vec_t v, input int idx);
        @(negedge clk);
        reset     = v.rst;
        a_valid   = v.av;
        a_data    = v.ad;
        a_last    = v.al;
        b_valid   = v.bv;
        b_data    = v.bd;
        b_last    = v.bl;
        out_ready = v.ordy;
        #1;
        check("a_ready", idx, DW'(a_ready), DW'(v.e_ar));
        check("b_ready", idx, DW'(b_ready), DW'(v.e_br));
        @(posedge clk);
        #1;
        check("out_valid", idx, DW'(out_valid), DW'(v.e_ov));
        if (v.e_ov) begin
            check("out_data", idx, out_data, v.e_od);
            check("out_last", idx, DW'(out_last), DW'(v.e_ol));
            check("out_src", idx, DW'(out_src), DW'(v.e_os));
        end
    endtask

    vec_t tbl[27];

    initial begin
        reset = 1'b1; a_valid = 1'b0; a_data = '0; a_last = 1'b0;
        b_valid = 1'b0; b_data = '0; b_last = 1'b0; out_ready = 1'b1;

        //            rst av ad     al bv bd     bl rdy  ar br ov od     ol os
        tbl[0]  = mk(1, 0, 'h00, 0, 0, 'h00, 0, 1,   0, 0, 0, 'h00, 0, 0);
        // A single-beat packets back to back
        tbl[1]  = mk(0, 1, 'h11, 1, 0, 'h00, 0, 1,   1, 0, 1, 'h11, 1, 0);
        tbl[2]  = mk(0, 1, 'h22, 1, 0, 'h00, 0, 1,   1, 0, 1, 'h22, 1, 0);
        tbl[3]  = mk(0, 1, 'h33, 1, 0, 'h00, 0, 1,   1, 0, 1, 'h33, 1, 0);
        tbl[4]  = mk(0, 0, 'h00, 0, 0, 'h00, 0, 1,   0, 0, 0, 'h00, 0, 0);
        tbl[5]  = mk(1, 0, 'h00, 0, 0, 'h00, 0, 1,   0, 0, 0, 'h00, 0, 0);
        // both streams single-beat, alternation starting with A
        tbl[6]  = mk(0, 1, 'hA0, 1, 1, 'hB0, 1, 1,   1, 0, 1, 'hA0, 1, 0);
        tbl[7]  = mk(0, 1, 'hA1, 1, 1, 'hB0, 1, 1,   0, 1, 1, 'hB0, 1, 1);
        tbl[8]  = mk(0, 1, 'hA1, 1, 1, 'hB1, 1, 1,   1, 0, 1, 'hA1, 1, 0);
        tbl[9]  = mk(0, 1, 'hA2, 1, 1, 'hB1, 1, 1,   0, 1, 1, 'hB1, 1, 1);
        // 3-beat A packet with B waiting
        tbl[10] = mk(0, 1, 'hC1, 0, 1, 'hB2, 1, 1,   1, 0, 1, 'hC1, 0, 0);
        tbl[11] = mk(0, 1, 'hC2, 0, 1, 'hB2, 1, 1,   1, 0, 1, 'hC2, 0, 0);
        tbl[12] = mk(0, 1, 'hC3, 1, 1, 'hB2, 1, 1,   1, 0, 1, 'hC3, 1, 0);
        tbl[13] = mk(0, 0, 'h00, 0, 1, 'hB2, 1, 1,   0, 1, 1, 'hB2, 1, 1);
        // backpressure for 4 cycles
        tbl[14] = mk(0, 1, 'hD1, 1, 0, 'h00, 0, 1,   1, 0, 1, 'hD1, 1, 0);
        tbl[15] = mk(0, 1, 'hD2, 1, 1, 'hB3, 1, 0,   0, 0, 1, 'hD1, 1, 0);
        tbl[16] = mk(0, 1, 'hD2, 1, 1, 'hB3, 1, 0,   0, 0, 1, 'hD1, 1, 0);
        tbl[17] = mk(0, 1, 'hD2, 1, 1, 'hB3, 1, 0,   0, 0, 1, 'hD1, 1, 0);
        tbl[18] = mk(0, 1, 'hD2, 1, 1, 'hB3, 1, 0,   0, 0, 1, 'hD1, 1, 0);
        tbl[19] = mk(0, 1, 'hD2, 1, 1, 'hB3, 1, 1,   0, 1, 1, 'hB3, 1, 1);
        tbl[20] = mk(0, 1, 'hD2, 1, 0, 'h00, 0, 1,   1, 0, 1, 'hD2, 1, 0);
        // A stalls mid-packet; lock holds and B is not granted
        tbl[21] = mk(0, 1, 'hE1, 0, 0, 'h00, 0, 1,   1, 0, 1, 'hE1, 0, 0);
        tbl[22] = mk(0, 0, 'h00, 0, 1, 'hB4, 1, 1,   1, 0, 0, 'h00, 0, 0);
        tbl[23] = mk(0, 0, 'h00, 0, 1, 'hB4, 1, 1,   1, 0, 0, 'h00, 0, 0);
        tbl[24] = mk(0, 1, 'hE2, 1, 1, 'hB4, 1, 1,   1, 0, 1, 'hE2, 1, 0);
        tbl[25] = mk(0, 0, 'h00, 0, 1, 'hB4, 1, 1,   0, 1, 1, 'hB4, 1, 1);
        tbl[26] = mk(0, 0, 'h00, 0, 0, 'h00, 0, 1,   0, 0, 0, 'h00, 0, 0);

        for (int i = 0; i < 27; i++) begin
            step(tbl[i], i);
        end

        // reset in the middle of an A packet: lock dropped, arbitration restarts at A
        step(mk(0, 1, 'hF1, 0, 1, 'hB5, 1, 1,   1, 0, 1, 'hF1, 0, 0), 100);
        step(mk(1, 1, 'hF2, 0, 1, 'hB5, 1, 1,   0, 0, 0, 'h00, 0, 0), 101);
        step(mk(0, 1, 'hF2, 0, 1, 'hB5, 1, 1,   1, 0, 1, 'hF2, 0, 0), 102);
        step(mk(0, 1, 'hF3, 1, 1, 'hB5, 1, 1,   1, 0, 1, 'hF3, 1, 0), 103);
        // reset in the middle of a B packet with ptr favouring B: A must win afterwards
        step(mk(0, 1, 'hF4, 1, 1, 'hC0, 0, 1,   0, 1, 1, 'hC0, 0, 1), 104);
        step(mk(1, 1, 'hF4, 1, 1, 'hC1, 0, 1,   0, 0, 0, 'h00, 0, 0), 105);
        step(mk(0, 1, 'hF4, 1, 1, 'hC1, 0, 1,   1, 0, 1, 'hF4, 1, 0), 106);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
